// File: rtl/color_matrix_pkg.sv
// Shared definitions for the colour-matrix pipeline: accumulator sizing,
// configuration address map and identity-matrix helper.
package color_matrix_pkg;

    // Configuration register map (cfg_addr); 12..15 are ignored
    localparam int unsigned CM_ADDR_M00   = 0;
    localparam int unsigned CM_ADDR_M01   = 1;
    localparam int unsigned CM_ADDR_M02   = 2;
    localparam int unsigned CM_ADDR_M10   = 3;
    localparam int unsigned CM_ADDR_M11   = 4;
    localparam int unsigned CM_ADDR_M12   = 5;
    localparam int unsigned CM_ADDR_M20   = 6;
    localparam int unsigned CM_ADDR_M21   = 7;
    localparam int unsigned CM_ADDR_M22   = 8;
    localparam int unsigned CM_ADDR_OFF_R = 9;
    localparam int unsigned CM_ADDR_OFF_G = 10;
    localparam int unsigned CM_ADDR_OFF_B = 11;

    localparam int unsigned CM_NCOEF = 9;
    localparam int unsigned CM_NCH   = 3;

    // Signed accumulator width: product plus growth for a 3-term signed sum
    function automatic int unsigned cm_accw(input int unsigned dsize, input int unsigned msize);
        return dsize + msize + 2;
    endfunction

    // Identity matrix coefficient (row-major index): 1.0 on the diagonal, 0 elsewhere
    function automatic int unsigned cm_ident_coef(input int unsigned idx, input int unsigned cfrac);
        return (idx == 0 || idx == 4 || idx == 8) ? (32'd1 << cfrac) : 32'd0;
    endfunction

endpackage

// File: rtl/cm_dot3.sv
// One output channel of the colour matrix: sign-magnitude 3-term dot product,
// scale, offset and clamp across five stall-able stages.
// COLOR_MATRIX_ROUND_EN: when defined, round half up before the scale shift;
// otherwise truncate (floor).
module cm_dot3
    import color_matrix_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned MSIZE = 8,
    parameter int unsigned CFRAC = 6,
    parameter int unsigned OSIZE = DSIZE + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        adv_i,
    input  logic [2:0][DSIZE-1:0]       pix_i,
    input  logic [2:0][MSIZE-1:0]       coef_i,
    input  logic [OSIZE-1:0]            off_i,
    output logic [DSIZE-1:0]            res_o
);

    localparam int unsigned PW   = DSIZE + MSIZE - 1;
    localparam int unsigned ACCW = cm_accw(DSIZE, MSIZE);
`ifdef COLOR_MATRIX_ROUND_EN
    localparam logic [ACCW-1:0] RND = ACCW'((32'd1 << CFRAC) >> 1);
`else
    localparam logic [ACCW-1:0] RND = '0;
`endif

    logic [2:0][PW-1:0]   mag_q,  mag_d;
    logic [2:0]           sgn_q,  sgn_d;
    logic [2:0][ACCW-1:0] term_q, term_d;
    logic [ACCW-1:0]      pair_q, pair_d;
    logic [ACCW-1:0]      col2_q, col2_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [DSIZE-1:0]     res_q,  res_d;
    logic [OSIZE-1:0]     off1_q, off2_q, off3_q;

    logic signed [ACCW-1:0] sum_c;
    logic signed [ACCW-1:0] shift_c;
    logic signed [ACCW-1:0] off_ext_c;

    // Next-state datapath for all five stages
    always_comb begin
        mag_d  = '0;
        sgn_d  = '0;
        term_d = '0;
        // S1: magnitude products, sign carried alongside
        for (int unsigned k = 0; k < 3; k++) begin
            mag_d[k] = PW'(pix_i[k]) * PW'(coef_i[k][MSIZE-2:0]);
            sgn_d[k] = coef_i[k][MSIZE-1];
        end
        // S2: two's-complement terms
        for (int unsigned k = 0; k < 3; k++) begin
            term_d[k] = sgn_q[k] ? (ACCW'(0) - ACCW'(mag_q[k])) : ACCW'(mag_q[k]);
        end
        // S3: partial sum
        pair_d = term_q[0] + term_q[1];
        col2_d = term_q[2];
        // S4: full sum, scale back to pixel units, add offset
        sum_c     = pair_q + col2_q + RND;
        shift_c   = sum_c >>> CFRAC;
        off_ext_c = {{(ACCW-OSIZE){off3_q[OSIZE-1]}}, off3_q};
        acc_d     = shift_c + off_ext_c;
        // S5: clamp to pixel range
        if (acc_q[ACCW-1]) begin
            res_d = '0;
        end else if (|acc_q[ACCW-2:DSIZE]) begin
            res_d = '1;
        end else begin
            res_d = acc_q[DSIZE-1:0];
        end
    end

    // Stage registers; everything holds while the pipe is stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mag_q  <= '0;
            sgn_q  <= '0;
            term_q <= '0;
            pair_q <= '0;
            col2_q <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            off1_q <= '0;
            off2_q <= '0;
            off3_q <= '0;
        end else if (adv_i) begin
            mag_q  <= mag_d;
            sgn_q  <= sgn_d;
            term_q <= term_d;
            pair_q <= pair_d;
            col2_q <= col2_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            off1_q <= off_i;
            off2_q <= off1_q;
            off3_q <= off2_q;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/color_matrix_pipe.sv
// 3x3 colour-space matrix with per-channel offset and clamp, valid/ready
// stream, and double-buffered coefficients swapped on a frame start.
// COLOR_MATRIX_ROUND_EN: when defined, results round half up instead of
// truncating (handled in cm_dot3; latency unchanged).
module color_matrix_pipe
    import color_matrix_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned MSIZE = 8,
    parameter int unsigned CFRAC = 6,
    parameter int unsigned OSIZE = DSIZE + 1
) (
    input  logic                                         clock,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic                                         in_sof,
    input  logic [DSIZE-1:0]                             in_r,
    input  logic [DSIZE-1:0]                             in_g,
    input  logic [DSIZE-1:0]                             in_b,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         out_sof,
    output logic [DSIZE-1:0]                             out_r,
    output logic [DSIZE-1:0]                             out_g,
    output logic [DSIZE-1:0]                             out_b,
    input  logic                                         cfg_we,
    input  logic [3:0]                                   cfg_addr,
    input  logic [((MSIZE > OSIZE) ? MSIZE : OSIZE)-1:0] cfg_wdata,
    input  logic                                         cfg_commit,
    output logic                                         cfg_pending
);

    logic [CM_NCOEF-1:0][MSIZE-1:0] shadow_m_q, shadow_m_d;
    logic [CM_NCOEF-1:0][MSIZE-1:0] active_m_q, active_m_d;
    logic [CM_NCH-1:0][OSIZE-1:0]   shadow_o_q, shadow_o_d;
    logic [CM_NCH-1:0][OSIZE-1:0]   active_o_q, active_o_d;
    logic                           pending_q,  pending_d;
    logic [4:0]                     vld_q,      vld_d;
    logic [4:0]                     sof_q,      sof_d;

    logic                           adv_c;
    logic                           apply_c;
    logic [CM_NCOEF-1:0][MSIZE-1:0] coef_eff_c;
    logic [CM_NCH-1:0][OSIZE-1:0]   off_eff_c;
    logic [CM_NCH-1:0][DSIZE-1:0]   row_res;

    assign adv_c    = !(vld_q[4] && !out_ready);
    assign in_ready = adv_c;
    // A sof beat accepted while a commit is armed takes the new set itself
    assign apply_c  = in_valid && adv_c && in_sof && pending_q;

    // Config banks, commit tracking and valid/sof pipe next state
    always_comb begin
        shadow_m_d = shadow_m_q;
        shadow_o_d = shadow_o_q;
        active_m_d = active_m_q;
        active_o_d = active_o_q;
        pending_d  = pending_q;
        vld_d      = vld_q;
        sof_d      = sof_q;

        if (cfg_we) begin
            for (int unsigned k = 0; k < CM_NCOEF; k++) begin
                if (cfg_addr == 4'(CM_ADDR_M00 + k)) shadow_m_d[k] = cfg_wdata[MSIZE-1:0];
            end
            for (int unsigned k = 0; k < CM_NCH; k++) begin
                if (cfg_addr == 4'(CM_ADDR_OFF_R + k)) shadow_o_d[k] = cfg_wdata[OSIZE-1:0];
            end
        end

        if (apply_c) begin
            active_m_d = shadow_m_q;
            active_o_d = shadow_o_q;
            pending_d  = 1'b0;
        end else if (cfg_commit) begin
            pending_d  = 1'b1;
        end

        if (adv_c) begin
            vld_d = {vld_q[3:0], in_valid};
            sof_d = {sof_q[3:0], in_valid && in_sof};
        end

        coef_eff_c = apply_c ? shadow_m_q : active_m_q;
        off_eff_c  = apply_c ? shadow_o_q : active_o_q;
    end

    // Control and config state; reset restores identity and drops the pipe
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int unsigned k = 0; k < CM_NCOEF; k++) begin
                shadow_m_q[k] <= MSIZE'(cm_ident_coef(k, CFRAC));
                active_m_q[k] <= MSIZE'(cm_ident_coef(k, CFRAC));
            end
            shadow_o_q <= '0;
            active_o_q <= '0;
            pending_q  <= 1'b0;
            vld_q      <= '0;
            sof_q      <= '0;
        end else begin
            shadow_m_q <= shadow_m_d;
            shadow_o_q <= shadow_o_d;
            active_m_q <= active_m_d;
            active_o_q <= active_o_d;
            pending_q  <= pending_d;
            vld_q      <= vld_d;
            sof_q      <= sof_d;
        end
    end

    // One dot-product row per output channel
    for (genvar r = 0; r < 3; r++) begin : g_row
        logic [2:0][MSIZE-1:0] row_coef;
        assign row_coef = {coef_eff_c[3*r+2], coef_eff_c[3*r+1], coef_eff_c[3*r]};

        cm_dot3 #(
            .DSIZE (DSIZE),
            .MSIZE (MSIZE),
            .CFRAC (CFRAC),
            .OSIZE (OSIZE)
        ) u_dot3 (
            .clk_i  (clock),
            .rst_i  (rst),
            .adv_i  (adv_c),
            .pix_i  ({in_b, in_g, in_r}),
            .coef_i (row_coef),
            .off_i  (off_eff_c[r]),
            .res_o  (row_res[r])
        );
    end

    assign out_valid   = vld_q[4];
    assign out_sof     = sof_q[4];
    assign out_r       = row_res[0];
    assign out_g       = row_res[1];
    assign out_b       = row_res[2];
    assign cfg_pending = pending_q;

endmodule

// File: tb/tb_color_matrix_pipe.sv
// Directed bench for color_matrix_pipe with an in-order expected-beat queue.
module tb_color_matrix_pipe;
    import color_matrix_pkg::*;

    logic       clock;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic [7:0] in_r, in_g, in_b;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic [7:0] out_r, out_g, out_b;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [8:0] cfg_wdata;
    logic       cfg_commit;
    logic       cfg_pending;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sof;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_tx    = 0;
    int   n_rx    = 0;

    color_matrix_pipe dut (
        .clock       (clock),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_r        (in_r),
        .in_g        (in_g),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sof     (out_sof),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_pending (cfg_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one beat and hold it until accepted; optionally record its expected output
    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic sof, input logic [7:0] er, input logic [7:0] eg,
                        input logic [7:0] eb, input bit track);
        int n;
        exp_t x;
        in_valid = 1'b1;
        in_sof   = sof;
        in_r     = r;
        in_g     = g;
        in_b     = b;
        if (track) begin
            x.r = er; x.g = eg; x.b = eb; x.sof = sof;
            exp_q.push_back(x);
            n_tx++;
        end
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("accept", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic cfg_write(input int unsigned addr, input logic [8:0] data, input logic commit);
        cfg_we     = 1'b1;
        cfg_addr   = 4'(addr);
        cfg_wdata  = data;
        cfg_commit = commit;
        @(posedge clock);
        #1;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Output monitor: every transferred beat must match the head of the queue
    always @(negedge clock) begin
        if (!rst && out_valid && out_ready) begin
            n_rx++;
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_r",   32'(out_r),   32'(e.r));
                check("out_g",   32'(out_g),   32'(e.g));
                check("out_b",   32'(out_b),   32'(e.b));
                check("out_sof", 32'(out_sof), 32'(e.sof));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        in_r = '0; in_g = '0; in_b = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_out_r",     32'(out_r),       32'd0);
        check("rst_out_g",     32'(out_g),       32'd0);
        check("rst_out_b",     32'(out_b),       32'd0);
        check("rst_pending",   32'(cfg_pending), 32'd0);
        check("rst_in_ready",  32'(in_ready),    32'd1);
        @(posedge clock);
        #1;
        rst = 1'b0;

        // Identity and five-cycle latency
        send(8'd100, 8'd150, 8'd200, 1'b0, 8'd100, 8'd150, 8'd200, 1'b1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid && n < 20);
        check("latency", 32'(n), 32'd5);
        @(posedge clock);
        #1;

        // Back-to-back beats, identity
        send(8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   8'd0,   1'b1);
        send(8'd255, 8'd255, 8'd255, 1'b0, 8'd255, 8'd255, 8'd255, 1'b1);
        send(8'd1,   8'd2,   8'd3,   1'b0, 8'd1,   8'd2,   8'd3,   1'b1);
        send(8'd10,  8'd20,  8'd30,  1'b1, 8'd10,  8'd20,  8'd30,  1'b1);
        drain();

        // Negative coefficient with offset, then clamp low
        cfg_write(CM_ADDR_M00, 9'h0C0, 1'b0);
        cfg_write(CM_ADDR_OFF_R, 9'd255, 1'b1);
        check("pending_set", 32'(cfg_pending), 32'd1);
        send(8'd100, 8'd150, 8'd200, 1'b1, 8'd155, 8'd150, 8'd200, 1'b1);
        check("pending_clr", 32'(cfg_pending), 32'd0);
        cfg_write(CM_ADDR_OFF_R, 9'd0, 1'b1);
        send(8'd100, 8'd150, 8'd200, 1'b1, 8'd0, 8'd150, 8'd200, 1'b1);
        drain();

        // Clamp high
        cfg_write(CM_ADDR_M00, 9'h07F, 1'b0);
        cfg_write(CM_ADDR_M01, 9'h07F, 1'b0);
        cfg_write(CM_ADDR_M02, 9'h07F, 1'b1);
        send(8'd255, 8'd255, 8'd255, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
        drain();

        // 0.5 * 3 = 1.5: floor or round-half-up
        cfg_write(CM_ADDR_M00, 9'h020, 1'b0);
        cfg_write(CM_ADDR_M01, 9'h000, 1'b0);
        cfg_write(CM_ADDR_M02, 9'h000, 1'b1);
`ifdef COLOR_MATRIX_ROUND_EN
        send(8'd3, 8'd0, 8'd0, 1'b1, 8'd2, 8'd0, 8'd0, 1'b1);
`else
        send(8'd3, 8'd0, 8'd0, 1'b1, 8'd1, 8'd0, 8'd0, 1'b1);
`endif
        drain();

        // Mid-frame commit waits for the next sof beat
        cfg_write(CM_ADDR_M00, 9'h040, 1'b1);
        check("swap_pending", 32'(cfg_pending), 32'd1);
        send(8'd100, 8'd0, 8'd0, 1'b0, 8'd50, 8'd0, 8'd0, 1'b1);
        check("swap_still_pending", 32'(cfg_pending), 32'd1);
        send(8'd100, 8'd0, 8'd0, 1'b1, 8'd100, 8'd0, 8'd0, 1'b1);
        check("swap_applied", 32'(cfg_pending), 32'd0);
        send(8'd7, 8'd8, 8'd9, 1'b1, 8'd7, 8'd8, 8'd9, 1'b1);
        check("sof_passthru_pending", 32'(cfg_pending), 32'd0);
        drain();

        // Backpressure: fill the pipe, hold for three cycles, then drain in order
        out_ready = 1'b0;
        send(8'd11, 8'd12, 8'd13, 1'b0, 8'd11, 8'd12, 8'd13, 1'b1);
        send(8'd21, 8'd22, 8'd23, 1'b0, 8'd21, 8'd22, 8'd23, 1'b1);
        send(8'd31, 8'd32, 8'd33, 1'b0, 8'd31, 8'd32, 8'd33, 1'b1);
        send(8'd41, 8'd42, 8'd43, 1'b0, 8'd41, 8'd42, 8'd43, 1'b1);
        send(8'd51, 8'd52, 8'd53, 1'b0, 8'd51, 8'd52, 8'd53, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready),  32'd0);
            check("stall_hold_r",   32'(out_r),     32'd11);
            check("stall_hold_b",   32'(out_b),     32'd13);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Reset with the pipe full and a commit armed
        out_ready = 1'b0;
        cfg_write(CM_ADDR_M00, 9'h0C0, 1'b1);
        check("pre_rst_pending", 32'(cfg_pending), 32'd1);
        for (int i = 0; i < 5; i++) begin
            send(8'(i + 60), 8'd1, 8'd2, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        end
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_valid",   32'(out_valid),   32'd0);
        check("post_rst_pending", 32'(cfg_pending), 32'd0);
        check("post_rst_out_r",   32'(out_r),       32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        // Write and commit together; M00 must be back to identity
        cfg_write(CM_ADDR_M11, 9'h020, 1'b1);
        send(8'd100, 8'd150, 8'd200, 1'b1, 8'd100, 8'd75, 8'd200, 1'b1);
        check("post_rst_apply", 32'(cfg_pending), 32'd0);
        drain();
        repeat (4) @(posedge clock);
        check("beat_count", 32'(n_rx), 32'(n_tx));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/color_matrix_pipe.md
Name: color_matrix_pipe

Overview:
Parametrised 3x3 colour-space matrix multiplier for the pixel pipeline, the successor to the fixed 8-bit matrix multiplier. It adds a valid/ready stream with backpressure, a per-channel signed offset and output clamping to pixel range. Coefficients are double-buffered and swap only at a frame boundary. It sits between the pixel source and the gamma/LUT stage.

Parameters:
DSIZE, 8, pixel component width (unsigned)
MSIZE, 8, coefficient width, sign-magnitude (bit MSIZE-1 = sign)
CFRAC, 6, fractional bits in coefficient magnitude (1.0 = 1<<CFRAC); must satisfy CFRAC <= MSIZE-2
OSIZE, DSIZE+1, offset width, two's complement, integer pixel units

Ports:
clock  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_sof  in  1  first pixel of frame, sideband of beat
in_r/in_g/in_b  in  DSIZE each  input components
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_sof  out  1  sof delayed with its beat
out_r/out_g/out_b  out  DSIZE each  clamped results
cfg_we  in  1  shadow write strobe
cfg_addr  in  4  0..8 = M00..M22 (row-major), 9..11 = offset R,G,B; 12..15 ignored
cfg_wdata  in  MSIZE (or OSIZE, whichever is larger)  write data, LSB-aligned
cfg_commit  in  1  arm shadow->active transfer
cfg_pending  out  1  commit armed, not yet applied

Behaviour:
- Reset: the synchronous rst is the only reset, active-high. All valid bits, out_*, cfg_pending are 0. Active and shadow coefficients reset to identity (diag = 1<<CFRAC, off-diag 0). Offsets reset to 0.
- Pipeline: 5 stages, latency 5 cycles from accepted beat to out_valid when not stalled.
  - S1: 9 magnitude products of width DSIZE+MSIZE-1, with sign bits registered alongside.
  - S2: apply sign (two's complement) in ACCW = DSIZE+MSIZE+2.
  - S3: pair-sum col0+col1, col2 registered.
  - S4: full sum, arithmetic shift right by CFRAC, add sign-extended offset.
  - S5: clamp to [0, 2^DSIZE-1].
- Stall: adv = !(out_valid && !out_ready); in_ready = adv. All stages advance only on adv.
  - Bubbles are not collapsed.
  - Outputs hold stable while stalled.
  - A beat is accepted iff in_valid && in_ready.
- Coefficient update:
  - cfg_we writes the shadow bank.
  - cfg_commit sets cfg_pending.
  - On the first accepted beat with in_sof=1 while pending, active <= shadow and pending clears. That beat and all later beats use the new set.
  - Beats already in flight keep the old coefficients; each stage carries the values it needs.
  - cfg_we and cfg_commit in the same cycle: the write is included.
  - Writes while pending: included if they occur before the apply cycle.
  - Commit in the same cycle as the apply: applies; pending stays 0.
- in_sof without pending: passes through only.
- Reset mid-stream: all in-flight beats are dropped. Config returns to identity.

Optional Feature:
COLOR_MATRIX_ROUND_EN
- Defined: add 1<<(CFRAC-1) before the S4 shift (round half up toward +inf).
- Undefined: truncate (floor via arithmetic shift).
- Latency is identical either way.

Decomposition:
- Package color_matrix_pkg holds:
  - ACCW calculation function
  - cfg address constants (CM_ADDR_M00..CM_ADDR_M22, CM_ADDR_OFF_R/G/B)
  - identity-coefficient constant function
- Sub-module cm_dot3: one row's sign-magnitude dot product, offset add and clamp (S1-S5). Instantiated 3 times. The top level holds the handshake, config banks and sof pipe.

Test Plan:
- Identity after reset, out_ready=1: in (100,150,200) -> out (100,150,200) exactly 5 cycles later; back-to-back beats at full rate.
- Negative coefficient and offset: shadow M00=0xC0 (-1.0), offset R=255, commit, sof beat R=100 -> out_r=155. Same with offset 0 -> out_r=0 (clamp low).
- Clamp high: M00=M01=M02=0x7F, in (255,255,255) -> out_r=255.
- Backpressure: out_ready low for 3 cycles with 5 beats in flight -> in_ready low, outputs stable, no beat lost or duplicated; order preserved.
- Frame-boundary swap: commit mid-frame -> cfg_pending=1. Beats stay on the old matrix until the next sof beat, which uses the new matrix; pending clears that cycle.
- Rounding: M00=0x20 (0.5), in_r=3 -> out_r=1 without COLOR_MATRIX_ROUND_EN, 2 with it.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 the next cycle, identity restored.
